// File: rtl/auth_status_pkg.sv
// Shared constants, transmitter state type and arbitration helpers for the
// authorization status transmitter.
package auth_status_pkg;

  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_S = 8'h53;

  localparam logic [7:0] RSP_ACK_G   = 8'h41;
  localparam logic [7:0] RSP_ACK_S   = 8'h4B;
  localparam logic [7:0] RSP_BAD     = 8'h3F;
  localparam logic [7:0] RSP_PWR_ON  = 8'h50;
  localparam logic [7:0] RSP_PWR_OFF = 8'h4F;
  localparam logic [7:0] RSP_BATT    = 8'h42;

  localparam int BAUD_DIV_DEF = 434;

  // Pending-flag bit positions; a lower index means a higher priority.
  localparam int NUM_EV     = 6;
  localparam int EV_ACK_G   = 0;
  localparam int EV_ACK_S   = 1;
  localparam int EV_BAD     = 2;
  localparam int EV_PWR_ON  = 3;
  localparam int EV_PWR_OFF = 4;
  localparam int EV_BATT    = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [NUM_EV-1:0] ev_grant(input logic [NUM_EV-1:0] pend);
    return pend & (~pend + 6'd1);
  endfunction

  function automatic logic [7:0] ev_code(input logic [NUM_EV-1:0] grant);
    logic [7:0] code;
    case (grant)
      6'b000001: code = RSP_ACK_G;
      6'b000010: code = RSP_ACK_S;
      6'b000100: code = RSP_BAD;
      6'b001000: code = RSP_PWR_ON;
      6'b010000: code = RSP_PWR_OFF;
      6'b100000: code = RSP_BATT;
      default:   code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/auth_status_tx_if.sv
// Bundle of the command/status inputs and the serial status outputs of
// auth_status_tx; the slave side is the transmitter block.
interface auth_status_tx_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       pwr_up;
  logic       batt_low;
  logic       TX;
  logic       busy;
  logic [7:0] frames_sent;

  modport master (
    output cmd_rdy, cmd, pwr_up, batt_low,
    input  TX, busy, frames_sent
  );

  modport slave (
    input  cmd_rdy, cmd, pwr_up, batt_low,
    output TX, busy, frames_sent
  );
endinterface

// File: rtl/status_uart_tx.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each BAUD_DIV clocks long. tx_done is high during the final stop clock.
module status_uart_tx
  import auth_status_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam int             CW            = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0]  BAUD_LAST     = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  BAUD_PRE      = (BAUD_DIV > 1) ? CW'(BAUD_DIV - 2) : CW'(0);
  localparam logic           HAS_PRE       = (BAUD_DIV > 1);
  localparam logic           LAST_IS_FIRST = (BAUD_DIV == 1);

  tx_state_t     state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;
  logic          baud_end_s;

  assign baud_end_s = (baud_cnt_r == BAUD_LAST);

  // Frame sequencer; done_r is raised one clock early so it covers the last stop clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= TX_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          done_r     <= 1'b0;
          if (trmt) begin
            state_r <= TX_START;
            shift_r <= tx_data;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            state_r    <= TX_DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              state_r <= TX_STOP;
              tx_r    <= 1'b1;
              done_r  <= LAST_IS_FIRST;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        TX_STOP: begin
          if (baud_end_s) begin
            state_r    <= TX_IDLE;
            baud_cnt_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
            done_r     <= HAS_PRE && (baud_cnt_r == BAUD_PRE);
          end
        end
        default: begin
          state_r <= TX_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TX      = tx_r;
  assign busy    = busy_r;
  assign tx_done = done_r;

endmodule

// File: rtl/auth_status_tx.sv
// Status reporter: latches command/power/battery events, arbitrates them by
// priority and sends one response byte per pending event over the UART.
module auth_status_tx
  import auth_status_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  auth_status_tx_if.slave  bus
);

  logic              pwr_q_r;
  logic              batt_q_r;
  logic [NUM_EV-1:0] pend_r;
  logic              trmt_r;
  logic [7:0]        tx_data_r;
  logic [7:0]        frames_r;

  logic [NUM_EV-1:0] set_s;
  logic [NUM_EV-1:0] grant_s;
  logic              idle_s;
  logic              load_s;
  logic              uart_tx_s;
  logic              uart_busy_s;
  logic              uart_done_s;

  // Event decode: command classification plus rising/falling level edges.
  always_comb begin
    set_s = {NUM_EV{1'b0}};
    if (bus.cmd_rdy) begin
      if (bus.cmd == CMD_G) begin
        set_s[EV_ACK_G] = 1'b1;
      end else if (bus.cmd == CMD_S) begin
        set_s[EV_ACK_S] = 1'b1;
      end else begin
        set_s[EV_BAD] = 1'b1;
      end
    end else begin
      set_s[EV_BAD] = 1'b0;
    end
    set_s[EV_PWR_ON]  = bus.pwr_up & ~pwr_q_r;
    set_s[EV_PWR_OFF] = ~bus.pwr_up & pwr_q_r;
    set_s[EV_BATT]    = bus.batt_low & ~batt_q_r;
  end

  // The final stop clock counts as idle so the next frame follows after one idle cycle.
  assign idle_s  = (~uart_busy_s | uart_done_s) & ~trmt_r;
  assign grant_s = idle_s ? ev_grant(pend_r) : {NUM_EV{1'b0}};
  assign load_s  = |grant_s;

  // Pending flags (set wins over the grant's clear), load register and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_q_r   <= 1'b0;
      batt_q_r  <= 1'b0;
      pend_r    <= {NUM_EV{1'b0}};
      trmt_r    <= 1'b0;
      tx_data_r <= 8'h00;
      frames_r  <= 8'h00;
    end else begin
      pwr_q_r  <= bus.pwr_up;
      batt_q_r <= bus.batt_low;
      pend_r   <= (pend_r & ~grant_s) | set_s;
      trmt_r   <= load_s;
      if (load_s) begin
        tx_data_r <= ev_code(grant_s);
      end else begin
        tx_data_r <= tx_data_r;
      end
      if (uart_done_s) begin
        frames_r <= frames_r + 8'd1;
      end else begin
        frames_r <= frames_r;
      end
    end
  end

  status_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt_r),
    .tx_data (tx_data_r),
    .TX      (uart_tx_s),
    .busy    (uart_busy_s),
    .tx_done (uart_done_s)
  );

  assign bus.TX          = uart_tx_s;
  assign bus.busy        = uart_busy_s;
  assign bus.frames_sent = frames_r;

endmodule

// File: tb/tb_auth_status_tx.sv
// Directed bench for auth_status_tx: a UART decoder pops expected bytes from
// a scoreboard queue; timing, counter and reset behaviour are checked inline.
module tb_auth_status_tx;
  import auth_status_pkg::*;

  localparam int B     = 10;
  localparam int FRAME = 10 * B;

  logic       clk = 1'b0;
  logic       rst;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_fs;
  int         cyc = 0;
  int         last_rst_cyc = -1;
  int         n_starts = 0;
  int         n_done = 0;
  int         n_abort = 0;
  int         starts [0:511];
  bit         mon_on = 1'b0;

  auth_status_tx_if bus();

  auth_status_tx #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) last_rst_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_frame(input logic [7:0] c);
    exp_q.push_back(c);
    exp_fs = exp_fs + 8'd1;
  endtask

  task automatic pulse_cmd(input logic [7:0] c);
    @(negedge clk);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = c;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    bus.cmd     = 8'h00;
  endtask

  task automatic wait_starts(input int target, input string tag);
    int k = 0;
    while (n_starts < target && k < 2 * FRAME + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, n_starts >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(exp_q.size() == 0 && bus.busy == 1'b0) && k < 8 * FRAME) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, (exp_q.size() == 0) && (bus.busy == 1'b0), 1);
  endtask

  // UART decoder: samples each bit at mid-period and scores the frame.
  initial begin : monitor
    logic [7:0] data;
    logic       start_b;
    logic       stop_b;
    logic [7:0] expb;
    int         s_cyc;
    wait (mon_on);
    forever begin
      @(negedge bus.TX);
      #1;
      s_cyc = cyc;
      if (n_starts < 512) starts[n_starts] = s_cyc;
      n_starts++;
      repeat (B / 2) @(posedge clk);
      #1; start_b = bus.TX;
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(posedge clk);
        #1; data[i] = bus.TX;
      end
      repeat (B) @(posedge clk);
      #1; stop_b = bus.TX;
      if (last_rst_cyc >= s_cyc) begin
        n_abort++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        check("start_bit", start_b, 1'b0);
        check("stop_bit", stop_b, 1'b1);
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          expb = exp_q.pop_front();
          check("frame_byte", data, expb);
        end
        n_done++;
      end
    end
  end

  initial begin : stim
    int s0;
    rst          = 1'b1;
    bus.cmd_rdy  = 1'b0;
    bus.cmd      = 8'h00;
    bus.pwr_up   = 1'b0;
    bus.batt_low = 1'b0;
    exp_fs       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", bus.TX, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_frames", bus.frames_sent, 8'h00);
    @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Basic 'G' -> 'A' with start-bit latency and busy width
    @(negedge clk);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = CMD_G;
    expect_frame(RSP_ACK_G);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    @(posedge clk); #1;
    check("lat_n1_tx", bus.TX, 1'b1);
    @(posedge clk); #1;
    check("lat_n2_tx", bus.TX, 1'b0);
    check("lat_n2_busy", bus.busy, 1'b1);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    check("busy_last_clk", bus.busy, 1'b1);
    @(posedge clk); #1;
    check("busy_end", bus.busy, 1'b0);
    check("frames_ack", bus.frames_sent, exp_fs);

    // Priority: 'G' together with pwr_up rise -> 'A' then 'P'
    s0 = n_starts;
    @(negedge clk);
    bus.cmd_rdy = 1'b1;
    bus.cmd     = CMD_G;
    bus.pwr_up  = 1'b1;
    expect_frame(RSP_ACK_G);
    expect_frame(RSP_PWR_ON);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    wait_starts(s0 + 2, "prio_starts");
    check("prio_pitch", starts[s0 + 1] - starts[s0], FRAME + 1);
    wait_idle("prio_idle");
    check("frames_prio", bus.frames_sent, exp_fs);

    // Unknown command
    expect_frame(RSP_BAD);
    pulse_cmd(8'h58);
    wait_idle("bad_idle");
    check("frames_bad", bus.frames_sent, exp_fs);

    // Coalescing of repeated 'S' during frames
    s0 = n_starts;
    expect_frame(RSP_ACK_G);
    pulse_cmd(CMD_G);
    wait_starts(s0 + 1, "coal_a_start");
    repeat (B) @(posedge clk);
    expect_frame(RSP_ACK_S);
    pulse_cmd(CMD_S);
    repeat (3) @(posedge clk);
    pulse_cmd(CMD_S);
    wait_starts(s0 + 2, "coal_k_start");
    repeat (2 * B) @(posedge clk);
    expect_frame(RSP_ACK_S);
    pulse_cmd(CMD_S);
    wait_idle("coal_idle");
    repeat (3 * B) @(posedge clk);
    #1;
    check("coal_frames", n_starts - s0, 3);
    check("frames_coal", bus.frames_sent, exp_fs);

    // Reset in the middle of a 'P' frame
    expect_frame(RSP_PWR_OFF);
    @(negedge clk);
    bus.pwr_up = 1'b0;
    wait_idle("off_idle");
    s0 = n_starts;
    exp_q.push_back(RSP_PWR_ON);
    @(negedge clk);
    bus.pwr_up = 1'b1;
    wait_starts(s0 + 1, "p_start");
    repeat (4 * B + 3) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    bus.pwr_up = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_tx", bus.TX, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    exp_fs = 8'h00;
    s0     = n_starts;
    repeat (10000) @(posedge clk);
    #1;
    check("quiet_starts", n_starts, s0);
    check("quiet_frames", bus.frames_sent, exp_fs);
    check("abort_count", n_abort, 1);
    check("quiet_sb", exp_q.size(), 0);

    // pwr_up high across reset release -> 'P'
    @(negedge clk);
    rst        = 1'b1;
    bus.pwr_up = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_frame(RSP_PWR_ON);
    wait_idle("rel_idle");
    check("frames_rel", bus.frames_sent, exp_fs);

    // Power off, battery low during that frame -> 'O' then 'B'
    s0 = n_starts;
    expect_frame(RSP_PWR_OFF);
    @(negedge clk);
    bus.pwr_up = 1'b0;
    wait_starts(s0 + 1, "o_start");
    repeat (B) @(posedge clk);
    expect_frame(RSP_BATT);
    @(negedge clk);
    bus.batt_low = 1'b1;
    wait_idle("ob_idle");
    check("frames_ob", bus.frames_sent, exp_fs);

    // Counter wrap: fill to 0xFF, then one more frame
    for (int k = 0; k < 252; k++) begin
      s0 = n_starts;
      expect_frame(RSP_ACK_G);
      pulse_cmd(CMD_G);
      wait_starts(s0 + 1, "wrap_start");
    end
    wait_idle("ff_idle");
    check("frames_ff", bus.frames_sent, exp_fs);
    expect_frame(RSP_ACK_G);
    pulse_cmd(CMD_G);
    wait_idle("wrap_idle");
    check("frames_wrap", bus.frames_sent, exp_fs);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
